// File: rtl/opfetch_pkg.sv
// Shared sizes and the ID/EX payload type for the operand fetch stage.
//   DATA_W       : operand/data width
//   AW           : register address width
//   NREG         : number of architectural registers (scoreboard depth)
//   idex_entry_t : operand A, operand B, destination, destination write enable
package opfetch_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned AW     = 5;
  localparam int unsigned NREG   = 32;

  typedef struct packed {
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [AW-1:0]     rd;
    logic              wen;
  } idex_entry_t;

endpackage

// File: rtl/opfetch_scoreboard.sv
// In-flight destination scoreboard: one busy bit per register, one producer each.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset (clears all bits)
//   set_en_i/addr_i   : mark a register busy (issued producer)
//   clr_en_i/addr_i   : mark a register free (write-back)
//   rd_a/b/w_addr_i   : lookup addresses (source A, source B, destination)
//   busy_a/b/w_c_o    : combinational lookup results on the registered vector
// A set and clear to the same address in one cycle leaves the bit set.
// Register 0 never reads busy.
module opfetch_scoreboard
  import opfetch_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          set_en_i,
  input  logic [AW-1:0] set_addr_i,
  input  logic          clr_en_i,
  input  logic [AW-1:0] clr_addr_i,
  input  logic [AW-1:0] rd_a_addr_i,
  input  logic [AW-1:0] rd_b_addr_i,
  input  logic [AW-1:0] rd_w_addr_i,
  output logic          busy_a_c_o,
  output logic          busy_b_c_o,
  output logic          busy_w_c_o
);

  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  // Clear first so a same-cycle set on the same address wins.
  always_comb begin
    busy_d = busy_q;
    if (clr_en_i) busy_d[clr_addr_i] = 1'b0;
    if (set_en_i) busy_d[set_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy_a_c_o = busy_q[rd_a_addr_i];
  assign busy_b_c_o = busy_q[rd_b_addr_i];
  assign busy_w_c_o = busy_q[rd_w_addr_i];

endmodule

// File: rtl/operand_fetch.sv
// Decode-to-execute operand fetch stage with RAW/WAW stall and a one-entry
// ID/EX register.
// Ports:
//   clk, rst                         : clock, asynchronous active-high reset
//   in_valid/in_ready                : decoded instruction handshake (in_ready comb)
//   in_rs/in_rt/in_use_rt            : sources; in_use_rt=0 selects in_imm for B
//   in_rd/in_wen/in_imm              : destination, its write enable, immediate
//   rf_raddr1/2, rf_rdata1/2         : register-file read port (addresses comb)
//   wb_we/wb_waddr/wb_wdata          : write-back bus (also frees scoreboard)
//   out_valid/out_ready              : ID/EX handshake
//   out_op_a/out_op_b/out_rd/out_wen : registered ID/EX payload
// Configuration macro OPFETCH_BYPASS_EN: when defined, a same-cycle write-back
// to a source register resolves the RAW via wb_wdata; otherwise the stage waits
// for the busy bit to clear and reads the register file.
module operand_fetch
  import opfetch_pkg::*;
#(
  parameter int unsigned DATA_W = opfetch_pkg::DATA_W,
  parameter int unsigned AW     = opfetch_pkg::AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [AW-1:0]     in_rs,
  input  logic [AW-1:0]     in_rt,
  input  logic              in_use_rt,
  input  logic [AW-1:0]     in_rd,
  input  logic              in_wen,
  input  logic [DATA_W-1:0] in_imm,
  output logic [AW-1:0]     rf_raddr1,
  output logic [AW-1:0]     rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op_a,
  output logic [DATA_W-1:0] out_op_b,
  output logic [AW-1:0]     out_rd,
  output logic              out_wen
);

  logic              busy_a;
  logic              busy_b;
  logic              busy_w;
  logic              byp_a;
  logic              byp_b;
  logic              raw_a;
  logic              raw_b;
  logic              waw;
  logic              hazard;
  logic              accept;
  logic              sb_set;
  logic [DATA_W-1:0] reg_a;
  logic [DATA_W-1:0] reg_b;

  logic              valid_q;
  logic              valid_d;
  idex_entry_t       entry_q;
  idex_entry_t       entry_d;

  assign rf_raddr1 = in_rs;
  assign rf_raddr2 = in_rt;

  opfetch_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .set_en_i    (sb_set),
    .set_addr_i  (in_rd),
    .clr_en_i    (wb_we),
    .clr_addr_i  (wb_waddr),
    .rd_a_addr_i (in_rs),
    .rd_b_addr_i (in_rt),
    .rd_w_addr_i (in_rd),
    .busy_a_c_o  (busy_a),
    .busy_b_c_o  (busy_b),
    .busy_w_c_o  (busy_w)
  );

`ifdef OPFETCH_BYPASS_EN
  assign byp_a = wb_we && (wb_waddr == in_rs) && (in_rs != '0);
  assign byp_b = wb_we && (wb_waddr == in_rt) && (in_rt != '0);

  // Register value: r0 is hard zero, then write-back bypass, then register file.
  always_comb begin
    reg_a = rf_rdata1;
    reg_b = rf_rdata2;
    if (byp_a)           reg_a = wb_wdata;
    if (byp_b)           reg_b = wb_wdata;
    if (in_rs == '0)     reg_a = '0;
    if (in_rt == '0)     reg_b = '0;
  end
`else
  logic unused_wdata;

  assign byp_a        = 1'b0;
  assign byp_b        = 1'b0;
  assign unused_wdata = ^wb_wdata;

  // Register value: r0 is hard zero, otherwise the register file.
  always_comb begin
    reg_a = rf_rdata1;
    reg_b = rf_rdata2;
    if (in_rs == '0) reg_a = '0;
    if (in_rt == '0) reg_b = '0;
  end
`endif

  // Hazards; a write-back to the destination this cycle lifts the WAW because
  // the scoreboard lets the new set win over the clear.
  assign raw_a  = busy_a && (in_rs != '0) && !byp_a;
  assign raw_b  = in_use_rt && busy_b && (in_rt != '0) && !byp_b;
  assign waw    = in_wen && (in_rd != '0) && busy_w && !(wb_we && (wb_waddr == in_rd));
  assign hazard = raw_a || raw_b || waw;

  assign in_ready = (!valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;
  assign sb_set   = accept && in_wen && (in_rd != '0);

  // ID/EX register next state: load on accept, drain on consume, else hold.
  always_comb begin
    valid_d = valid_q;
    entry_d = entry_q;
    if (accept) begin
      valid_d      = 1'b1;
      entry_d.op_a = reg_a;
      entry_d.op_b = in_use_rt ? reg_b : in_imm;
      entry_d.rd   = in_rd;
      entry_d.wen  = in_wen;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else begin
      valid_q <= valid_d;
      entry_q <= entry_d;
    end
  end

  assign out_valid = valid_q;
  assign out_op_a  = entry_q.op_a;
  assign out_op_b  = entry_q.op_b;
  assign out_rd    = entry_q.rd;
  assign out_wen   = entry_q.wen;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a small register-file model.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic        in_use_rt;
  logic [4:0]  in_rd;
  logic        in_wen;
  logic [31:0] in_imm;
  logic [4:0]  rf_raddr1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata1;
  logic [31:0] rf_rdata2;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_op_a;
  logic [31:0] out_op_b;
  logic [4:0]  out_rd;
  logic        out_wen;

  int checks = 0;
  int errs   = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rs     (in_rs),
    .in_rt     (in_rt),
    .in_use_rt (in_use_rt),
    .in_rd     (in_rd),
    .in_wen    (in_wen),
    .in_imm    (in_imm),
    .rf_raddr1 (rf_raddr1),
    .rf_raddr2 (rf_raddr2),
    .rf_rdata1 (rf_rdata1),
    .rf_rdata2 (rf_rdata2),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op_a  (out_op_a),
    .out_op_b  (out_op_b),
    .out_rd    (out_rd),
    .out_wen   (out_wen)
  );

  // Register file model: unwritten entries hold their own index, r0 holds 0x1234
  // so the stage's hard-zero on r0 is visible.
  logic [31:0] rf_wr [32];
  logic [31:0] wr_flag = '0;

  function automatic logic [31:0] rf_val(input logic [4:0] a);
    if (wr_flag[a]) return rf_wr[a];
    if (a == 5'd0)  return 32'h1234;
    return 32'(a);
  endfunction

  always @(posedge clk) begin
    if (wb_we) begin
      rf_wr[wb_waddr]   <= wb_wdata;
      wr_flag[wb_waddr] <= 1'b1;
    end
  end

  always_comb begin
    rf_rdata1 = rf_val(rf_raddr1);
    rf_rdata2 = rf_val(rf_raddr2);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic use_rt, input logic [4:0] rd, input logic wen,
                       input logic [31:0] imm);
    in_valid  = v;
    in_rs     = rs;
    in_rt     = rt;
    in_use_rt = use_rt;
    in_rd     = rd;
    in_wen    = wen;
    in_imm    = imm;
  endtask

  task automatic wb(input logic we, input logic [4:0] a, input logic [31:0] d);
    wb_we    = we;
    wb_waddr = a;
    wb_wdata = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    wb(1'b0, 5'd0, 32'h0);
    step();
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_op_a",  out_op_a,       32'd0);
    check("rst_op_b",  out_op_b,       32'd0);
    check("rst_rd",    32'(out_rd),    32'd0);
    check("rst_wen",   32'(out_wen),   32'd0);
    rst = 1'b0;

    // Independent stream, back-to-back.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd1, 5'd2, 1'b1, 5'(10 + i), 1'b0, 32'h0);
      #1;
      check("ind_ready", 32'(in_ready), 32'd1);
      step();
      check("ind_valid", 32'(out_valid), 32'd1);
      check("ind_op_a",  out_op_a,       32'd1);
      check("ind_op_b",  out_op_b,       32'd2);
      check("ind_rd",    32'(out_rd),    32'(10 + i));
    end
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    step();
    check("ind_drain", 32'(out_valid), 32'd0);

    // RAW on r5 with write-back arriving alongside the dependent.
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 32'h0);
    #1;
    step();
    drive(1'b1, 5'd5, 5'd0, 1'b0, 5'd3, 1'b0, 32'h77);
    wb(1'b1, 5'd5, 32'hDEAD);
    #1;
`ifdef OPFETCH_BYPASS_EN
    check("raw_ready", 32'(in_ready), 32'd1);
    step();
    wb(1'b0, 5'd0, 32'h0);
    check("raw_valid", 32'(out_valid), 32'd1);
    check("raw_op_a",  out_op_a,       32'hDEAD);
    check("raw_op_b",  out_op_b,       32'h77);
`else
    check("raw_ready", 32'(in_ready), 32'd0);
    step();
    wb(1'b0, 5'd0, 32'h0);
    check("raw_bubble", 32'(out_valid), 32'd0);
    #1;
    check("raw_ready2", 32'(in_ready), 32'd1);
    step();
    check("raw_valid", 32'(out_valid), 32'd1);
    check("raw_op_a",  out_op_a,       32'hDEAD);
    check("raw_op_b",  out_op_b,       32'h77);
`endif
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    step();

    // WAW on r7, released by a colliding write-back that leaves r7 busy.
    drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 32'h0);
    #1;
    step();
    drive(1'b1, 5'd1, 5'd0, 1'b0, 5'd7, 1'b1, 32'h11);
    #1;
    check("waw_stall", 32'(in_ready), 32'd0);
    step();
    #1;
    check("waw_stall2", 32'(in_ready), 32'd0);
    wb(1'b1, 5'd7, 32'h99);
    #1;
    check("waw_clear", 32'(in_ready), 32'd1);
    step();
    wb(1'b0, 5'd0, 32'h0);
    check("waw_valid", 32'(out_valid), 32'd1);
    check("waw_rd",    32'(out_rd),    32'd7);
    check("waw_wen",   32'(out_wen),   32'd1);
    check("waw_op_b",  out_op_b,       32'h11);
    drive(1'b1, 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    #1;
    check("busy7_kept", 32'(in_ready), 32'd0);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    wb(1'b1, 5'd7, 32'h99);
    step();
    wb(1'b0, 5'd0, 32'h0);
    step();

    // Backpressure: entry held for three cycles.
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd9, 1'b0, 32'h0);
    #1;
    check("bp_ready0", 32'(in_ready), 32'd1);
    step();
    drive(1'b1, 5'd2, 5'd1, 1'b1, 5'd11, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_ready",  32'(in_ready),  32'd0);
      check("bp_valid",  32'(out_valid), 32'd1);
      check("bp_rd",     32'(out_rd),    32'd9);
      check("bp_op_a",   out_op_a,       32'd1);
      step();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release", 32'(in_ready), 32'd1);
    step();
    check("bp_next_rd",   32'(out_rd), 32'd11);
    check("bp_next_op_a", out_op_a,    32'd2);
    check("bp_next_op_b", out_op_b,    32'd1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    step();

    // r0 reads as zero and a write to r0 never stalls.
    drive(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 32'h5);
    #1;
    check("r0_ready", 32'(in_ready), 32'd1);
    step();
    check("r0_op_a", out_op_a,     32'd0);
    check("r0_op_b", out_op_b,     32'd0);
    check("r0_wen",  32'(out_wen), 32'd1);
    check("r0_rd",   32'(out_rd),  32'd0);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd4, 1'b0, 32'h5);
    #1;
    check("r0_no_stall", 32'(in_ready), 32'd1);
    step();
    check("r0_op_a2", out_op_a, 32'd0);
    check("r0_imm",   out_op_b, 32'h5);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    step();

    // Reset while an entry is held; scoreboard must come back clear.
    out_ready = 1'b0;
    drive(1'b1, 5'd1, 5'd2, 1'b1, 5'd12, 1'b1, 32'h0);
    #1;
    step();
    check("mr_held", 32'(out_valid), 32'd1);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    #2;
    rst = 1'b1;
    #1;
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_wen",   32'(out_wen),   32'd0);
    check("mr_rd",    32'(out_rd),    32'd0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 5'd12, 5'd0, 1'b0, 5'd3, 1'b0, 32'h0);
    #1;
    check("mr_ready", 32'(in_ready), 32'd1);
    step();
    check("mr_first_valid", 32'(out_valid), 32'd1);
    check("mr_first_op_a",  out_op_a,       32'd12);
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, errs);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

Decode-to-execute operand fetch stage that sits directly upstream of the register file. Accepts decoded instructions, drives the register file's two read addresses, captures operands into a one-entry ID/EX pipeline register, and tracks in-flight destination registers in a 32-entry scoreboard. It stalls on RAW and WAW hazards and, optionally, bypasses the write-back value.

## Interface
Parameters:
- DATA_W, 32, operand/data width
- AW, 5, register address width (32 registers)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts instruction this cycle
- in_rs  in  AW  source A register
- in_rt  in  AW  source B register
- in_use_rt  in  1  source B is a register (else immediate)
- in_rd  in  AW  destination register
- in_wen  in  1  instruction writes in_rd
- in_imm  in  DATA_W  sign-extended immediate
- rf_raddr1  out  AW  register-file read address A (= in_rs, combinational)
- rf_raddr2  out  AW  register-file read address B (= in_rt, combinational)
- rf_rdata1  in  DATA_W  register-file read data A
- rf_rdata2  in  DATA_W  register-file read data B
- wb_we  in  1  write-back strobe (same signal drives the register file)
- wb_waddr  in  AW  write-back address
- wb_wdata  in  DATA_W  write-back data
- out_valid  out  1  ID/EX entry valid
- out_ready  in  1  execute consumes entry
- out_op_a  out  DATA_W  operand A
- out_op_b  out  DATA_W  operand B (register value or in_imm)
- out_rd  out  AW  destination
- out_wen  out  1  destination write enable

## Operation
- Register 0: always reads as 0 in this stage; never marked busy; in_wen with in_rd=0 is forwarded but not scoreboarded.
- busy[31:0] scoreboard, one producer per register.
- raw_a = busy[in_rs] && in_rs!=0 && !byp_a; raw_b = in_use_rt && busy[in_rt] && in_rt!=0 && !byp_b.
- byp_x = wb_we && wb_waddr==src && src!=0 (with macro only; else byp_x=0).
- waw = in_wen && in_rd!=0 && busy[in_rd] && !(wb_we && wb_waddr==in_rd).
- hazard = raw_a || raw_b || waw.
- in_ready = (!out_valid || out_ready) && !hazard. Accept = in_valid && in_ready.
- Operand mux: addr 0 -> 0; byp -> wb_wdata; else rf_rdata. op_b = in_use_rt ? reg value : in_imm.
- Scoreboard update per cycle: clear busy[wb_waddr] on wb_we; set busy[in_rd] on accept with in_wen && in_rd!=0. Same address set and clear in the same cycle: set wins.
- wb_we to a non-busy register: busy is unchanged (stays 0).

## Timing
- Reset (async): out_valid=0, out_op_a=0, out_op_b=0, out_rd=0, out_wen=0, busy=0.
- in_ready, rf_raddr1, and rf_raddr2 are combinational. in_ready must not depend on in_valid.
- Latency: accept in cycle N gives out_valid=1 with captured fields in N+1.
- Output register holds stable while out_valid && !out_ready.
- Full throughput: accept every cycle when out_ready=1 and there is no hazard.
- out_valid && out_ready && !accept: out_valid falls next cycle.
- Reset mid-stall: entry is dropped and the scoreboard clears. Downstream is reset by the same rst.

## Configuration
- OPFETCH_BYPASS_EN defined: a write-back in cycle N satisfies a RAW in cycle N via wb_wdata; accept in N.
- Undefined: byp=0. Stall until the busy bit clears (cycle N+1), then read the register file. This costs one extra bubble per dependency and removes the wb_wdata compare/mux.

## Structure
- Package opfetch_pkg: DATA_W, AW, NREG=32, and a typedef for the ID/EX entry struct (op_a, op_b, rd, wen).
- Sub-module opfetch_scoreboard: busy vector, set/clear ports, two read lookups plus WAW lookup. The top module holds the hazard logic, operand mux, and pipeline register.

## Test plan
- Reset: assert rst mid-transfer with out_valid=1 -> out_valid=0, busy=0 immediately; first instruction after release is accepted in 1 cycle.
- Independent stream: rs=1, rt=2 (RF holds 1, 2), out_ready=1, 4 back-to-back -> 4 outputs in 4 consecutive cycles, op_a=1, op_b=2.
- RAW with bypass: issue rd=5 wen, then rs=5; wb_we=1, waddr=5, wdata=0xDEAD in the same cycle as the dependent arrives -> accepted that cycle, op_a=0xDEAD. Without the macro: accepted one cycle later, op_a from the register file.
- WAW plus set/clear collision: rd=7 busy; new rd=7 is stalled until wb_waddr=7. In the clearing cycle it is accepted and busy[7] remains 1.
- Backpressure: out_ready=0 for 3 cycles with an entry held -> outputs stable, in_ready=0; then out_ready=1 -> next entry is taken.
- r0: rs=0 while the register file returns 0x1234 -> op_a=0. Write to rd=0 never stalls a later rs=0 read.
